imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-fetch interface: receives a byte stream, assembles 16-bit instruction words and writes them sequentially into instruction RAM from address 0.
- Holds the CPU in reset until a complete, checksum-verified program is loaded; it then releases the hold so fetch starts reading from address 0.
- Sits between the host byte link and the instruction-memory write port, beside fetch/decode/execution.

Parameters:
- ADDR_W, 8, instruction-memory address width; capacity DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-RAM write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- cpu_hold  out  1  holds the CPU in reset while high.
- busy  out  1  a load is in progress.
- done  out  1  load succeeded; stays high until the next start.
- err  out  1  load failed; stays high until the next start.
- words_written  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then N words sent as hi byte then lo byte, then CSUM. CSUM is the XOR of every preceding byte in the frame.
- Byte transfer: a byte is accepted on a rising clk edge when in_valid and in_ready are both high. in_ready is high only in states S_LEN_HI, S_LEN_LO, S_DHI, S_DLO, S_CSUM. The loader never drops or duplicates a byte, and in_valid may stall for any number of cycles.
- States and transitions:
  - IDLE, start -> S_LEN_HI. On entry, clear word counter, XOR accumulator, done and err.
  - S_LEN_HI, accept -> S_LEN_LO.
  - S_LEN_LO, accept -> N latched:
    - N > DEPTH -> ERR.
    - N == 0 -> S_CSUM.
    - otherwise -> S_DHI.
  - S_DHI, accept -> S_DLO. S_DLO, accept -> S_WR.
  - S_WR: exactly one cycle with mem_we=1, mem_addr = counter[ADDR_W-1:0], mem_wdata = {hi,lo}. The counter increments at the end of the cycle. Next state is S_CSUM if the incremented counter == N, else S_DHI.
  - S_CSUM, accept: byte == accumulator -> DONE, else -> ERR.
  - DONE, ERR: start -> S_LEN_HI, with the same clears as from IDLE. Other inputs are ignored.
- mem_we, mem_addr and mem_wdata are decoded from registered state, so they are glitch-free. mem_we=0 outside S_WR. mem_addr and mem_wdata are 0 outside S_WR.
- Per-word throughput: minimum 3 cycles (2 byte cycles plus 1 write cycle). A full load takes at least 1 + 2 + 3N + 1 cycles from start.
- Flag outputs:
  - cpu_hold=1 in every state except DONE; a failed load keeps the CPU held.
  - busy=1 in S_LEN_HI through S_CSUM.
  - done=1 only in DONE; err=1 only in ERR.
  - words_written is the counter value and is held in DONE and ERR.
- start while busy is ignored. A simultaneous start and byte acceptance in DONE or ERR accepts no byte, because in_ready=0 there.
- Reset (at any time, including mid-load): immediately state=IDLE, cpu_hold=1, in_ready=0, mem_we=0, busy=0, done=0, err=0, words_written=0, mem_addr=0, mem_wdata=0. Words already written to RAM are not undone.
- Arithmetic: N is 16-bit. The comparison against DEPTH is unsigned. The counter is ADDR_W+1 bits wide so N == DEPTH terminates correctly without wrapping.

Decomposition:
- Package loader_pkg: state encoding constants (IDLE, S_LEN_HI, S_LEN_LO, S_DHI, S_DLO, S_WR, S_CSUM, DONE, ERR) and frame-field byte-order constants.
- One sub-module, loader_csum: an 8-bit XOR accumulator with clear, enable and byte input, reset asynchronously to 0.
- The FSM, word assembly and counter stay in imem_loader.

Test Plan:
- Reset state: assert rst mid-run -> all outputs 0 except cpu_hold=1. Release, then no start for 10 cycles -> state stays IDLE, in_ready=0.
- Nominal load: start, bytes 00 02 12 34 AB CD, CSUM = 00^02^12^34^AB^CD = 0x42 -> two writes: (0,0x1234), (1,0xABCD). Then done=1, cpu_hold=0, words_written=2.
- Stalled stream: the same frame with in_valid low for 3 cycles between every byte -> identical writes. No extra mem_we pulses.
- Bad checksum: frame 00 01 00 05 with CSUM 0x00 (correct value 0x04) -> one write (0,0x0005), then err=1, cpu_hold=1.
- Boundaries:
  - N=0, frame 00 00 00 -> done=1 with no writes.
  - N=0x0101 with ADDR_W=8 -> err=1 immediately after LEN_LO, no writes.
  - N=256 -> last write at address 255, then DONE.
- Restart and reset mid-load:
  - start during S_DLO -> ignored.
  - rst during S_DLO -> IDLE, outputs cleared.
  - A subsequent start and valid frame completes normally; start from DONE reloads and clears done.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared state encoding and frame layout constants for the instruction-memory loader.
package loader_pkg;

  // Loader FSM states
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    S_LEN_HI = 4'd1,
    S_LEN_LO = 4'd2,
    S_DHI    = 4'd3,
    S_DLO    = 4'd4,
    S_WR     = 4'd5,
    S_CSUM   = 4'd6,
    DONE     = 4'd7,
    ERR      = 4'd8
  } state_t;

  // Frame field widths; multi-byte fields travel big-endian (high byte first)
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned HI_LSB = 8;

  // States in which the loader takes a byte from the stream
  function automatic logic is_rx_state(state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DHI) ||
           (s == S_DLO)    || (s == S_CSUM);
  endfunction

  // States that make up an in-progress load
  function automatic logic is_busy_state(state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DHI) ||
           (s == S_DLO)    || (s == S_WR)     || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/loader_csum.sv
// Running XOR of frame bytes, compared against the trailing checksum byte.
module loader_csum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] acc_o
);

  logic [BYTE_W-1:0] acc_q;

  // Clear wins over accumulate so a restart never folds in a stale byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q ^ byte_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checked program into instruction RAM and
// keeps the CPU held in reset until a good image is in place.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [WORD_W-1:0]   wdata_d;

  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                cpu_hold_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                accept_c;
  logic                csum_clr_c;
  logic                csum_en_c;
  logic [BYTE_W-1:0]   csum_acc;
  logic [LEN_W-1:0]    len_new_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  loader_csum u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (csum_clr_c),
    .en_i   (csum_en_c),
    .byte_i (in_byte),
    .acc_o  (csum_acc)
  );

  assign accept_c  = in_valid & in_ready_q;
  assign len_new_c = {len_q[LEN_W-1:HI_LSB], in_byte};
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state, word assembly and write-port values for the coming cycle
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    addr_d     = '0;
    wdata_d    = '0;
    csum_clr_c = 1'b0;
    csum_en_c  = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          cnt_d      = '0;
          csum_clr_c = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (accept_c) begin
          len_d     = {in_byte, len_q[HI_LSB-1:0]};
          csum_en_c = 1'b1;
          state_d   = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept_c) begin
          len_d     = len_new_c;
          csum_en_c = 1'b1;
          if (32'(len_new_c) > DEPTH) begin
            state_d = ERR;
          end else if (len_new_c == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DHI;
          end
        end
      end
      S_DHI: begin
        if (accept_c) begin
          hi_d      = in_byte;
          csum_en_c = 1'b1;
          state_d   = S_DLO;
        end
      end
      S_DLO: begin
        if (accept_c) begin
          csum_en_c = 1'b1;
          addr_d    = cnt_q[ADDR_W-1:0];
          wdata_d   = {hi_q, in_byte};
          state_d   = S_WR;
        end
      end
      S_WR: begin
        cnt_d = cnt_inc_c;
        if (32'(cnt_inc_c) == 32'(len_q)) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DHI;
        end
      end
      S_CSUM: begin
        if (accept_c) begin
          state_d = (in_byte == csum_acc) ? DONE : ERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and all outputs registered from the next-state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      hi_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= is_rx_state(state_d);
      mem_we_q    <= (state_d == S_WR);
      mem_addr_q  <= addr_d;
      mem_wdata_q <= wdata_d;
      cpu_hold_q  <= (state_d != DONE);
      busy_q      <= is_busy_state(state_d);
      done_q      <= (state_d == DONE);
      err_q       <= (state_d == ERR);
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, stalls, checksum errors, length limits, restarts.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;

  typedef logic [7:0] bq_t [$];

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_written;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wa_q [$];
  logic [15:0]       wd_q [$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_byte       (in_byte),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  // Log every RAM write, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake: byte %02h never accepted, in_ready=%b required 1", b, in_ready);
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic send_frame(input bq_t f, input int gap);
    foreach (f[i]) begin
      send_byte(f[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, mem_we, busy, done, err, cpu_hold, words_written, mem_addr, mem_wdata} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 8'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_initial: rdy=%b we=%b busy=%b done=%b err=%b hold=%b ww=%0d required hold=1 others 0",
               in_ready, mem_we, busy, done, err, cpu_hold, words_written);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({in_ready, busy, cpu_hold, done, err} !== 5'b00100) begin
      n_bad++;
      $display("FAIL idle_no_start: rdy=%b busy=%b hold=%b done=%b err=%b required 0 0 1 0 0",
               in_ready, busy, cpu_hold, done, err);
    end
    // Reset in the middle of a load
    do_start();
    send_frame('{8'h00, 8'h02, 8'h12}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, mem_we, busy, done, err, cpu_hold, words_written, mem_addr, mem_wdata} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 8'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_midrun: rdy=%b we=%b busy=%b done=%b err=%b hold=%b ww=%0d required hold=1 others 0",
               in_ready, mem_we, busy, done, err, cpu_hold, words_written);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal(input int gap, input string tag);
    clear_log();
    do_start();
    send_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}, gap);
    @(negedge clk);
    n_cmp++;
    if ({done, err, cpu_hold, busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL %s_flags: done=%b err=%b hold=%b busy=%b required 1 0 0 0", tag, done, err, cpu_hold, busy);
    end
    n_cmp++;
    if (words_written !== 9'd2) begin
      n_bad++;
      $display("FAIL %s_count: words_written=%0d required 2", tag, words_written);
    end
    n_cmp++;
    if (wa_q.size() != 2) begin
      n_bad++;
      $display("FAIL %s_nwrites: writes=%0d required 2", tag, wa_q.size());
    end else if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== {8'd0, 16'h1234, 8'd1, 16'hABCD}) begin
      n_bad++;
      $display("FAIL %s_writes: (%0d,%04h) (%0d,%04h) required (0,1234) (1,abcd)",
               tag, wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
    end
  endtask

  task automatic test_bad_csum();
    clear_log();
    do_start();
    send_frame('{8'h00, 8'h01, 8'h00, 8'h05, 8'h00}, 0);
    @(negedge clk);
    n_cmp++;
    if ({err, done, cpu_hold, busy, in_ready} !== 5'b10100) begin
      n_bad++;
      $display("FAIL bad_csum_flags: err=%b done=%b hold=%b busy=%b rdy=%b required 1 0 1 0 0",
               err, done, cpu_hold, busy, in_ready);
    end
    n_cmp++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'd0 || wd_q[0] !== 16'h0005 || words_written !== 9'd1) begin
      n_bad++;
      $display("FAIL bad_csum_write: writes=%0d ww=%0d required one write (0,0005) ww=1",
               wa_q.size(), words_written);
    end
  endtask

  task automatic test_len_zero();
    clear_log();
    do_start();
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    @(negedge clk);
    n_cmp++;
    if ({done, err, cpu_hold} !== 3'b100 || wa_q.size() != 0 || words_written !== 9'd0) begin
      n_bad++;
      $display("FAIL len_zero: done=%b err=%b hold=%b writes=%0d ww=%0d required 1 0 0, 0 writes, ww=0",
               done, err, cpu_hold, wa_q.size(), words_written);
    end
  endtask

  task automatic test_len_too_big();
    clear_log();
    do_start();
    send_frame('{8'h01, 8'h01}, 0);
    @(negedge clk);
    n_cmp++;
    if ({err, done, cpu_hold, busy, in_ready} !== 5'b10100 || wa_q.size() != 0) begin
      n_bad++;
      $display("FAIL len_too_big: err=%b done=%b hold=%b busy=%b rdy=%b writes=%0d required 1 0 1 0 0, 0 writes",
               err, done, cpu_hold, busy, in_ready, wa_q.size());
    end
  endtask

  task automatic test_len_full();
    bq_t f;
    logic [7:0] cs;
    int seq_bad;
    f = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      f.push_back(8'(i) ^ 8'h5A);
      f.push_back(8'(i));
    end
    cs = 8'h00;
    foreach (f[i]) cs = cs ^ f[i];
    f.push_back(cs);
    clear_log();
    do_start();
    send_frame(f, 0);
    @(negedge clk);
    n_cmp++;
    if ({done, err, cpu_hold} !== 3'b100 || words_written !== 9'h100) begin
      n_bad++;
      $display("FAIL len_full_flags: done=%b err=%b hold=%b ww=%0d required 1 0 0 ww=256",
               done, err, cpu_hold, words_written);
    end
    n_cmp++;
    if (wa_q.size() != 256) begin
      n_bad++;
      $display("FAIL len_full_nwrites: writes=%0d required 256", wa_q.size());
    end else begin
      seq_bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (wa_q[i] !== 8'(i) || wd_q[i] !== {8'(i) ^ 8'h5A, 8'(i)}) seq_bad++;
      end
      if (seq_bad != 0 || wa_q[255] !== 8'hFF || wd_q[255] !== 16'hA5FF) begin
        n_bad++;
        $display("FAIL len_full_writes: %0d bad entries, last (%0d,%04h) required (255,a5ff)",
                 seq_bad, wa_q[255], wd_q[255]);
      end
    end
  endtask

  task automatic test_restart();
    // start while in S_DLO must be ignored
    clear_log();
    do_start();
    send_frame('{8'h00, 8'h01, 8'h12}, 0);
    do_start();
    n_cmp++;
    if ({busy, in_ready, words_written} !== {1'b1, 1'b1, 9'd0}) begin
      n_bad++;
      $display("FAIL start_while_busy: busy=%b rdy=%b ww=%0d required 1 1 0", busy, in_ready, words_written);
    end
    send_frame('{8'h34, 8'h27}, 0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || wa_q.size() != 1 || wd_q[0] !== 16'h1234) begin
      n_bad++;
      $display("FAIL start_ignored_result: done=%b writes=%0d required done=1 one write 1234", done, wa_q.size());
    end
    // start from DONE with a byte offered at the same time: no byte taken
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h99;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    n_cmp++;
    if ({done, busy, cpu_hold, in_ready} !== 4'b0111) begin
      n_bad++;
      $display("FAIL restart_from_done: done=%b busy=%b hold=%b rdy=%b required 0 1 1 1",
               done, busy, cpu_hold, in_ready);
    end
    clear_log();
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || wa_q.size() != 0) begin
      n_bad++;
      $display("FAIL restart_no_byte_taken: done=%b writes=%0d required 1 0", done, wa_q.size());
    end
    // reset while in S_DLO, then a clean load
    do_start();
    send_frame('{8'h00, 8'h01, 8'hAB}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, mem_we, busy, done, err, cpu_hold, words_written} !== {6'b000001, 9'd0}) begin
      n_bad++;
      $display("FAIL reset_in_dlo: rdy=%b we=%b busy=%b done=%b err=%b hold=%b ww=%0d required hold=1 others 0",
               in_ready, mem_we, busy, done, err, cpu_hold, words_written);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    do_start();
    send_frame('{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50}, 0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || wa_q.size() != 1 || wd_q[0] !== 16'hBEEF || words_written !== 9'd1) begin
      n_bad++;
      $display("FAIL reload_after_reset: done=%b hold=%b writes=%0d ww=%0d required 1 0, one write beef, ww=1",
               done, cpu_hold, wa_q.size(), words_written);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    test_reset();
    test_nominal(0, "nominal");
    test_nominal(3, "stalled");
    test_bad_csum();
    test_len_zero();
    test_len_too_big();
    test_len_full();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
